// File: rtl/audio_capture_buffer.sv
// Audio capture buffer: multi-frame circular sample RAM between I2S receive and the DSP engine.
// Ports: iomem_* host bus (RAM window at ADDR+0x000, regs at ADDR+0x400), sample_* capture input,
//        eng_* engine read port (1-cycle latency), frame/frame_done/irq status outputs.
// Latency: bus ack one cycle after request; engine read data one cycle after eng_raddr. No backpressure on capture.
module audio_capture_buffer #(
  parameter logic [15:0] ADDR     = 16'h7000,
  parameter int          CHANNELS = 16,
  parameter int          FRAMES   = 32,
  parameter int          SAMPLE_W = 16
) (
  input  logic                               ck,
  input  logic                               rst,
  input  logic                               iomem_valid,
  output logic                               iomem_ready,
  input  logic [3:0]                         iomem_wstrb,
  input  logic [31:0]                        iomem_addr,
  input  logic [31:0]                        iomem_wdata,
  output logic [31:0]                        iomem_rdata,
  input  logic                               sample_valid,
  input  logic [$clog2(CHANNELS)-1:0]        sample_chan,
  input  logic [SAMPLE_W-1:0]                sample_data,
  input  logic                               sample_last,
  input  logic                               eng_busy,
  input  logic [$clog2(FRAMES)-1:0]          eng_frame,
  input  logic [$clog2(FRAMES*CHANNELS)-1:0] eng_raddr,
  output logic [SAMPLE_W-1:0]                eng_rdata,
  output logic [$clog2(FRAMES)-1:0]          frame,
  output logic                               frame_done,
  output logic                               irq
);

  localparam int          CW      = $clog2(CHANNELS);
  localparam int          FW      = $clog2(FRAMES);
  localparam int          AW      = CW + FW;
  localparam int          DEPTH   = FRAMES * CHANNELS;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];

  logic                ready_q, acked_q, rd_ram_q;
  logic [31:0]         reg_rdata_q;
  logic [SAMPLE_W-1:0] bus_ram_q, eng_rdata_q;
  logic [FW-1:0]       wr_frame_q, wr_frame_d, frame_q, frame_d;
  logic [CW-1:0]       chan_unused_guard;
  logic [CHANNELS-1:0] chan_mask_q, chan_mask_d;
  logic                enable_q, enable_d, irq_en_q, irq_en_d, frame_reset_q, frame_reset_d;
  logic                ovf_q, ovf_d, short_q, short_d, frame_done_q, frame_done_d;

  // Address decode. Registers take priority over the RAM words they overlap.
  logic [13:0] word_off;
  logic        base_hit, sel_ctl, sel_sts, sel_clr, reg_hit, ram_hit, accept, host_wr;
  logic [AW-1:0] ram_idx;

  assign word_off = iomem_addr[15:2];
  assign base_hit = iomem_valid && (iomem_addr[31:16] == ADDR);
  assign sel_ctl  = (word_off == 14'h100);
  assign sel_sts  = (word_off == 14'h101);
  assign sel_clr  = (word_off == 14'h102);
  assign reg_hit  = sel_ctl | sel_sts | sel_clr;
  assign ram_hit  = !reg_hit && (iomem_addr[15:11] == 5'd0) && ({18'd0, word_off} < DEPTH_W);
  // One ack per request: acked_q blocks re-acceptance until valid drops.
  assign accept   = base_hit && (reg_hit || ram_hit) && !ready_q && !acked_q;
  assign host_wr  = accept && (iomem_wstrb != 4'd0);
  assign ram_idx  = iomem_addr[2 +: AW];

  // Capture path
  logic                cap;
  logic [CHANNELS-1:0] chan_bit, mask_now;
  logic [FW-1:0]       next_frame;

  assign cap        = enable_q && sample_valid;
  assign chan_bit   = {{(CHANNELS-1){1'b0}}, 1'b1} << sample_chan;
  assign mask_now   = chan_mask_q | chan_bit;
  assign next_frame = wr_frame_q + 1'b1;  // FRAMES is a power of 2, so this wraps
  assign chan_unused_guard = sample_chan;

  // RAM write port: capture owns it while enabled, host only while disabled.
  logic                ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [SAMPLE_W-1:0] ram_wdata;

  assign ram_we    = cap || (host_wr && ram_hit && !enable_q);
  assign ram_waddr = cap ? {wr_frame_q, sample_chan} : ram_idx;
  assign ram_wdata = cap ? sample_data : iomem_wdata[SAMPLE_W-1:0];

  always_ff @(posedge ck) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
  end

  always_comb begin
    wr_frame_d    = wr_frame_q;
    frame_d       = frame_q;
    chan_mask_d   = chan_mask_q;
    enable_d      = enable_q;
    irq_en_d      = irq_en_q;
    frame_reset_d = 1'b0;
    ovf_d         = ovf_q;
    short_d       = short_q;
    frame_done_d  = 1'b0;

    // Clear is applied before the set events below so a same-cycle set wins.
    if (host_wr && sel_clr) begin
      if (iomem_wdata[16]) ovf_d   = 1'b0;
      if (iomem_wdata[17]) short_d = 1'b0;
    end
    if (host_wr && sel_ctl) begin
      enable_d      = iomem_wdata[0];
      irq_en_d      = iomem_wdata[1];
      frame_reset_d = iomem_wdata[2];
    end

    if (cap) begin
      chan_mask_d = mask_now;
      if (sample_last) begin
        if (mask_now != {CHANNELS{1'b1}}) short_d = 1'b1;
        chan_mask_d = '0;
        if (eng_busy && (next_frame == eng_frame)) begin
          // Engine still owns the next slot: stay put and overwrite this frame.
          ovf_d = 1'b1;
        end else begin
          frame_d      = wr_frame_q;
          wr_frame_d   = next_frame;
          frame_done_d = 1'b1;
        end
      end
    end

    if (frame_reset_q) begin
      wr_frame_d  = '0;
      chan_mask_d = '0;
    end
  end

  // Register read mux, captured at accept time.
  logic [31:0] reg_rdata;
  always_comb begin
    reg_rdata = '0;
    if (sel_ctl) begin
      reg_rdata[2:0] = {frame_reset_q, irq_en_q, enable_q};
    end else if (sel_sts) begin
      reg_rdata[7:0]  = {{(8-FW){1'b0}}, wr_frame_q};
      reg_rdata[15:8] = {{(8-FW){1'b0}}, frame_q};
      reg_rdata[16]   = ovf_q;
      reg_rdata[17]   = short_q;
      reg_rdata[18]   = enable_q;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      ready_q       <= 1'b0;
      acked_q       <= 1'b0;
      rd_ram_q      <= 1'b0;
      reg_rdata_q   <= '0;
      bus_ram_q     <= '0;
      eng_rdata_q   <= '0;
      wr_frame_q    <= '0;
      frame_q       <= '1;
      chan_mask_q   <= '0;
      enable_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      frame_reset_q <= 1'b0;
      ovf_q         <= 1'b0;
      short_q       <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      ready_q       <= accept;
      acked_q       <= iomem_valid && (acked_q || ready_q);
      if (accept) begin
        rd_ram_q    <= ram_hit && !host_wr;
        reg_rdata_q <= host_wr ? 32'd0 : reg_rdata;
        bus_ram_q   <= mem_q[ram_idx];
      end
      eng_rdata_q   <= mem_q[eng_raddr];
      wr_frame_q    <= wr_frame_d;
      frame_q       <= frame_d;
      chan_mask_q   <= chan_mask_d;
      enable_q      <= enable_d;
      irq_en_q      <= irq_en_d;
      frame_reset_q <= frame_reset_d;
      ovf_q         <= ovf_d;
      short_q       <= short_d;
      frame_done_q  <= frame_done_d;
    end
  end

  logic [31:0] ram_rd_ext;
  always_comb begin
    ram_rd_ext = '0;
    ram_rd_ext[SAMPLE_W-1:0] = bus_ram_q;
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = !ready_q ? 32'd0 : (rd_ram_q ? ram_rd_ext : reg_rdata_q);
  assign eng_rdata   = eng_rdata_q;
  assign frame       = frame_q;
  assign frame_done  = frame_done_q;
  assign irq         = (ovf_q | short_q) & irq_en_q;

  // Bus bits that carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{iomem_wdata, iomem_addr[1:0], chan_unused_guard};

endmodule
